// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives PS/2 keyboard frames and decodes the scan-code set 2 stream of
//   make, break (F0) and extended (E0) codes. It holds the code of the key
//   that is currently pressed for the VGA controller (key_in / key_en).
//
// Ports
//   iCLK       in   system clock; all logic runs on the rising edge
//   iRST_n     in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   key_code   out  low byte of the held key's make code, 0 when no key is held
//   key_en     out  one-cycle pulse on every accepted make code
//   key_ext    out  1 when the held key was E0-prefixed
//   frame_err  out  one-cycle pulse on a parity or stop-bit error
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_en,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and clock glitch filter
  // ---------------------------------------------------------------------------
  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] filt_sr_q;
  logic                  filt_clk_q;
  logic                  fall_d;
  logic                  data_bit_d;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_sr_q   <= '1;
      filt_clk_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
      // Level only moves once the whole window agrees; otherwise it holds.
      if (&filt_sr_q) begin
        filt_clk_q <= 1'b1;
      end else if (~|filt_sr_q) begin
        filt_clk_q <= 1'b0;
      end
    end
  end

  // The fall pulse fires in the single cycle where the filter window is all
  // zeros while the filtered level is still high.
  assign fall_d     = filt_clk_q & ~|filt_sr_q;
  assign data_bit_d = data_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          rx_valid_q;
  logic [7:0]    rx_byte_q;
  logic          frame_err_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // Inside a frame the idle counter restarts on every clock fall; when it
      // runs out the partial frame is dropped without reporting an error.
      if (state_q != S_IDLE) begin
        if (fall_d) begin
          tmo_cnt_q <= '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          tmo_cnt_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (fall_d && !data_bit_d) begin
            state_q   <= S_DATA;
            bit_cnt_q <= 3'd0;
            tmo_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (fall_d) begin
            shift_q   <= {data_bit_d, shift_q[7:1]};  // LSB arrives first
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_q <= S_IDLE;
          end
        end
        S_PARITY: begin
          if (fall_d) begin
            parity_q <= data_bit_d;
            state_q  <= S_STOP;
          end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_q <= S_IDLE;
          end
        end
        S_STOP: begin
          if (fall_d) begin
            // Odd parity over data + parity bit, and stop bit must be high.
            if (data_bit_d && (^{parity_q, shift_q})) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code decoder
  // ---------------------------------------------------------------------------
  logic [7:0] key_code_q;
  logic       key_ext_q;
  logic       key_en_q;
  logic       ext_pend_q;
  logic       brk_pend_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      key_code_q <= 8'd0;
      key_ext_q  <= 1'b0;
      key_en_q   <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      key_en_q <= 1'b0;
      if (frame_err_q) begin
        // A corrupted byte may have been part of a prefix sequence.
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (rx_valid_q) begin
        if (rx_byte_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (rx_byte_q == 8'hF0) begin
          brk_pend_q <= 1'b1;
        end else if (brk_pend_q) begin
          // Only releasing the key we are holding clears it.
          if ((rx_byte_q == key_code_q) && (ext_pend_q == key_ext_q)) begin
            key_code_q <= 8'd0;
            key_ext_q  <= 1'b0;
          end
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end else begin
          key_code_q <= rx_byte_q;
          key_ext_q  <= ext_pend_q;
          key_en_q   <= 1'b1;
          ext_pend_q <= 1'b0;
        end
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_en    = key_en_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Drives PS/2 frames onto the decoder pins and checks every cycle against a
//   byte-level model of the scan-code rules. Output timing is derived from the
//   pin edge: 2 synchroniser cycles + FILTER_LEN filter cycles to the internal
//   fall, then frame_err one cycle later and the key outputs one more later.
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;
  localparam int ERR_LAT = 2 + FL + 1;   // pin fall -> frame_err cycle
  localparam int KEY_LAT = ERR_LAT + 1;  // pin fall -> key outputs visible

  logic       iCLK = 1'b0;
  logic       iRST_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_en;
  logic       key_ext;
  logic       frame_err;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_en    (key_en),
    .key_ext   (key_ext),
    .frame_err (frame_err)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Byte-level model state
  logic [7:0] m_code = 8'h00;
  bit         m_ext = 1'b0;
  bit         ext_p = 1'b0;
  bit         brk_p = 1'b0;
  // What the outputs must show, and when scheduled changes land
  logic [7:0] exp_code = 8'h00;
  bit         exp_ext = 1'b0;
  bit         exp_en;
  bit         exp_err;
  int         sk_cyc = -1;
  int         se_cyc = -1;
  logic [7:0] sk_code = 8'h00;
  bit         sk_ext = 1'b0;
  bit         sk_en = 1'b0;
  bit         chk_on = 1'b0;
  int         en_cnt = 0;
  int         err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge iCLK) begin
    if (chk_on) begin
      if (cyc == sk_cyc) begin
        exp_code = sk_code;
        exp_ext  = sk_ext;
      end
      exp_en  = (cyc == sk_cyc) && sk_en;
      exp_err = (cyc == se_cyc);
      check("key_code", key_code, exp_code);
      check("key_ext", key_ext, exp_ext);
      check("key_en", key_en, exp_en);
      check("frame_err", frame_err, exp_err);
      if (key_en) en_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  // Apply the scan-code rules to one received frame whose stop-bit pin fall
  // happened in cycle c0.
  task automatic model_frame(input logic [7:0] b, input bit valid, input int c0);
    if (!valid) begin
      se_cyc = c0 + ERR_LAT;
      ext_p = 1'b0;
      brk_p = 1'b0;
    end else if (b == 8'hE0) begin
      ext_p = 1'b1;
    end else if (b == 8'hF0) begin
      brk_p = 1'b1;
    end else if (brk_p) begin
      if (b == m_code && ext_p == m_ext) begin
        m_code = 8'h00;
        m_ext = 1'b0;
        sk_cyc = c0 + KEY_LAT;
        sk_code = 8'h00;
        sk_ext = 1'b0;
        sk_en = 1'b0;
      end
      brk_p = 1'b0;
      ext_p = 1'b0;
    end else begin
      m_code = b;
      m_ext = ext_p;
      ext_p = 1'b0;
      sk_cyc = c0 + KEY_LAT;
      sk_code = b;
      sk_ext = m_ext;
      sk_en = 1'b1;
    end
  endtask

  // One PS/2 bit: data set while clock high, then a full low/high clock period.
  task automatic send_bit(input bit b, output int c0);
    ps2_data = b;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    c0 = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int c0;
    bit par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, c0);
    for (int i = 0; i < 8; i++) send_bit(b[i], c0);
    send_bit(par, c0);
    // Stop bit: model is updated right at the pin fall so the schedule is ahead.
    ps2_data = ~bad_stop;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    c0 = cyc;
    model_frame(b, !(bad_par || bad_stop), c0);
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF / 2);
    ps2_data = 1'b1;
    $display("[TB] frame %02h par_err=%0d stop_err=%0d -> model key %02h ext %0d",
             b, bad_par, bad_stop, m_code, m_ext);
  endtask

  task automatic do_reset();
    iRST_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    m_code = 8'h00; m_ext = 1'b0; ext_p = 1'b0; brk_p = 1'b0;
    exp_code = 8'h00; exp_ext = 1'b0;
    sk_cyc = -1; se_cyc = -1;
    #1;
    check("rst_key_code", key_code, 8'h00);
    check("rst_key_ext", key_ext, 1'b0);
    check("rst_key_en", key_en, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    tick(3);
    iRST_n = 1'b1;
    tick(15);
  endtask

  task automatic glitch(input int len);
    ps2_data = 1'b0;
    tick(2);
    ps2_clk = 1'b0;
    tick(len);
    ps2_clk = 1'b1;
    tick(15);
    ps2_data = 1'b1;
    tick(5);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, c0;
    logic [7:0] makes [10];
    logic [7:0] b;
    makes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h5A, 8'h29};

    tick(2);
    do_reset();
    chk_on = 1'b1;

    // E0 75 -> extended right arrow held
    e0 = en_cnt;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("t1_code", key_code, 8'h75);
    check("t1_ext", key_ext, 1'b1);
    check("t1_en_pulses", en_cnt - e0, 1);

    // E0 F0 75 -> release
    e0 = en_cnt;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("t2_code", key_code, 8'h00);
    check("t2_ext", key_ext, 1'b0);
    check("t2_en_pulses", en_cnt - e0, 0);

    // 6B, 74, F0 6B -> 74 stays held
    e0 = en_cnt;
    send_frame(8'h6B, 0, 0);
    send_frame(8'h74, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    check("t3_code", key_code, 8'h74);
    check("t3_en_pulses", en_cnt - e0, 2);

    // Release 74, then a bad-parity 72 followed by a good one
    send_frame(8'hF0, 0, 0);
    send_frame(8'h74, 0, 0);
    r0 = err_cnt;
    send_frame(8'h72, 1, 0);
    check("t4_code_after_err", key_code, 8'h00);
    check("t4_err_pulses", err_cnt - r0, 1);
    send_frame(8'h72, 0, 0);
    check("t4_code", key_code, 8'h72);

    // Partial frame abandoned by timeout, then a full 6B
    r0 = err_cnt;
    send_bit(1'b0, c0);
    send_bit(1'b1, c0);
    send_bit(1'b0, c0);
    send_bit(1'b1, c0);
    tick(TO + 10);
    send_frame(8'h6B, 0, 0);
    check("t5_err_pulses", err_cnt - r0, 0);
    check("t5_code", key_code, 8'h6B);

    // 5-cycle glitch with data low must not start a frame
    glitch(5);
    send_frame(8'h74, 0, 0);
    check("t6_code", key_code, 8'h74);

    // Reset mid-frame while 75 is held, then decode 75 again
    send_frame(8'h75, 0, 0);
    check("t7_code_before", key_code, 8'h75);
    for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1, c0);
    do_reset();
    send_frame(8'h75, 0, 0);
    check("t7_code_after", key_code, 8'h75);
    check("t7_ext_after", key_ext, 1'b0);

    // Randomised stream
    for (int n = 0; n < 70; n++) begin
      int r;
      bit bp, bs;
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else if (r < 6 && m_code != 8'h00) b = m_code;
      else b = makes[$urandom_range(0, 9)];
      bp = 1'b0;
      bs = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) bp = 1'b1;
        else bs = 1'b1;
      end
      send_frame(b, bp, bs);
      if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 5));
      tick($urandom_range(0, 30));
    end

    tick(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames and decodes the set-2 make/break/extended scan-code stream.
- Drives the held key code and new-key strobe consumed by the VGA controller's key_in/key_en inputs.
- Sits directly upstream of the VGA controller, between the board PS/2 pins and the display logic.
- key_code holds the currently pressed key (0 when none), so downstream logic can act on a held arrow key.

Parameters:
- FILTER_LEN, 8: number of consecutive equal iCLK samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYC, 50000: idle iCLK cycles inside a frame before the partial frame is abandoned (1 ms at 50 MHz).

Ports:
- iCLK  input  1  system clock; all logic on posedge.
- iRST_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- key_code  output  8  low byte of the currently held key's make code; 0 when no key is held.
- key_en  output  1  one-cycle pulse on every accepted make code, including typematic repeats.
- key_ext  output  1  1 if the held key_code was E0-prefixed.
- frame_err  output  1  one-cycle pulse on a parity or stop-bit error.

Behaviour:
- Reset (asynchronous, iRST_n=0):
  - key_code=0, key_en=0, key_ext=0, frame_err=0.
  - FSM=IDLE; all flags, counters and filters cleared; filtered clk=1.
  - Reset mid-frame discards the partial frame.
- Synchronisation and filtering:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - ps2_clk then feeds a FILTER_LEN shift register; the filtered level changes only when all FILTER_LEN samples agree.
  - fall = filtered 1->0 transition; it is a one-cycle pulse.
  - Data is sampled only on fall.
- Receive FSM:
  - IDLE: on fall with data=0 (start bit) -> DATA, bit_cnt=0. On fall with data=1, stay in IDLE (spurious edge ignored).
  - DATA: on each fall, shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: on fall, capture the parity bit -> STOP.
  - STOP: on fall, the frame is valid if stop=1 and the 9 bits (8 data + parity) hold an odd number of 1s. Go to IDLE.
    - Valid frame: rx_valid pulses the next cycle.
    - Invalid frame: frame_err pulses the next cycle; the byte is discarded and the break/ext pending flags are cleared.
  - Timeout: in DATA/PARITY/STOP, a cycle counter resets on every fall. If it reaches TIMEOUT_CYC -> IDLE; partial frame discarded silently, no frame_err.
- Byte decoder (acts on the rx_valid cycle):
  - 0xE0: set ext_pend.
  - 0xF0: set brk_pend.
  - Other byte B with brk_pend=1 (break):
    - if B==key_code and ext_pend==key_ext, then key_code<=0 and key_ext<=0;
    - otherwise the held key is unchanged.
    - Clear both flags.
  - Other byte B with brk_pend=0 (make): key_code<=B, key_ext<=ext_pend, key_en=1 for one cycle; clear ext_pend.
  - 0xE0 followed by 0xF0 keeps both flags (extended break sequence E0 F0 xx).
- Latency:
  - Stop-bit fall detected in cycle N.
  - rx_valid/frame_err asserted in cycle N+1.
  - key_code/key_ext/key_en updated at the end of cycle N+1 and visible from cycle N+2.
- A new make replaces any held key; there is no multi-key tracking.
- key_en and frame_err are never asserted in the same cycle.
- Glitches shorter than FILTER_LEN cycles on ps2_clk produce no fall.

Test Plan:
- Frame E0 then frame 75, both with correct odd parity and stop=1 -> key_code=0x75 and key_ext=1 exactly 2 cycles after the second stop-bit fall; key_en high for exactly one cycle.
- Sequence E0 75, then E0 F0 75 -> key_code returns to 0x00 and key_ext to 0; no key_en pulse on the break.
- Make 6B, make 74, then break 6B (F0 6B) -> key_code=0x74 after the second make and remains 0x74 after the 6B break; key_en pulsed twice.
- Byte 0x72 sent with wrong parity bit (0 instead of 1), then a correct 0x72 frame -> first frame gives one frame_err pulse and key_code stays 0; second frame gives key_code=0x72.
- Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYC+10 cycles, then a full 0x6B frame -> no frame_err; key_code=0x6B.
- 5-cycle low glitch on ps2_clk in IDLE with data=0 -> FSM stays in IDLE. Separately, assert iRST_n=0 mid-frame with key_code=0x75 -> all outputs 0 immediately; the next full frame 0x75 decodes normally.
